// File: rtl/freqsep_bank.sv
// freqsep_bank: per-band peak-hold / linear-decay level engine with RGB mapping.
// Each band keeps a level and a hold counter. New peaks load the level and
// restart the hold; a shared prescaler produces decay ticks. A sequenced clear
// zeroes one band per cycle while input is blocked.
module freqsep_bank #(
    parameter int CHANNELS   = 4,
    parameter int MAG_W      = 12,
    parameter int HOLD_TICKS = 2,
    parameter int TICK_DIV   = 4,
    parameter int DECAY_STEP = 256,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic                    mag_valid,
    output logic                    mag_ready,
    input  logic [CH_W-1:0]         mag_channel,
    input  logic [MAG_W-1:0]        mag_data,
    input  logic                    clear_req,
    input  logic                    mode,
    output logic [CHANNELS*24-1:0]  freqsep_export,
    output logic                    overflow_err
);

    localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [CH_W-1:0]   IDX_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [CH_W:0]     CH_LIMIT  = (CH_W + 1)'(CHANNELS);

    // Decay step clamped to MAG_W+1 bits; a step at or above full scale
    // simply drives any level straight to zero.
    localparam logic [MAG_W:0] STEP_C =
        (DECAY_STEP >= (1 << MAG_W)) ? (MAG_W + 1)'(1 << MAG_W)
                                     : (MAG_W + 1)'(DECAY_STEP);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_mag_ready;
    logic [CH_W-1:0]   r_idx;
    logic [PRE_W-1:0]  r_presc;
    logic              r_overflow;

    logic              w_accept;
    logic              w_tick;
    logic              w_chan_oob;

    assign w_accept   = mag_valid && r_mag_ready;
    assign w_tick     = (r_presc == PRE_LAST);
    assign w_chan_oob = ({1'b0, mag_channel} >= CH_LIMIT);

    assign mag_ready    = r_mag_ready;
    assign overflow_err = r_overflow;

    // Free-running prescaler; only reset restarts its phase.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    // Clear sequencer: walks idx over all bands with input blocked.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state     <= ST_IDLE;
            r_mag_ready <= 1'b1;
            r_idx       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_req) begin
                        r_state     <= ST_CLEAR;
                        r_mag_ready <= 1'b0;
                        r_idx       <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (r_idx == IDX_LAST) begin
                        r_state     <= ST_IDLE;
                        r_mag_ready <= 1'b1;
                        r_idx       <= '0;
                    end else begin
                        r_idx <= r_idx + CH_W'(1);
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_mag_ready <= 1'b1;
                    r_idx       <= '0;
                end
            endcase
        end
    end

    // Sticky flag for samples addressed past the last band.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_overflow <= 1'b0;
        end else if (w_accept && w_chan_oob) begin
            r_overflow <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [MAG_W-1:0]  r_level;
            logic [HOLD_W-1:0] r_hold;
            logic [23:0]       r_rgb;
            logic              w_raise;
            logic              w_clr;
            logic [7:0]        w_l8;

            assign w_raise = w_accept && (mag_channel == CH_W'(gi))
                             && (mag_data >= r_level);
            assign w_clr   = (r_state == ST_CLEAR) && (r_idx == CH_W'(gi));
            assign w_l8    = r_level[MAG_W-1 -: 8];

            // Level update priority: clear, then a raising sample, then decay tick.
            always_ff @(posedge clk_clk) begin
                if (reset_reset || w_clr) begin
                    r_level <= '0;
                    r_hold  <= '0;
                end else if (w_raise) begin
                    r_level <= mag_data;
                    r_hold  <= HOLD_LOAD;
                end else if (w_tick) begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end else if ({1'b0, r_level} > STEP_C) begin
                        r_level <= r_level - STEP_C[MAG_W-1:0];
                    end else begin
                        r_level <= '0;
                    end
                end
            end

            // Registered colour word rebuilt every cycle from level and mode.
            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    r_rgb <= '0;
                end else if (mode) begin
                    r_rgb <= {w_l8, w_l8, w_l8};
                end else begin
                    r_rgb <= {w_l8, 8'hFF - w_l8, 8'h00};
                end
            end

            assign freqsep_export[24*gi +: 24] = r_rgb;
        end
    endgenerate

endmodule

// File: tb/tb_freqsep_bank.sv
// Bench for freqsep_bank: directed scenarios plus random traffic, every cycle
// compared against a queue/array model of the band levels.
module tb_freqsep_bank;

    localparam int NCH = 4;
    localparam int MW  = 12;
    localparam int HT  = 2;
    localparam int TD  = 4;
    localparam int DS  = 256;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst        = 1'b1;
    logic        mag_valid   = 1'b0;
    logic [1:0]  mag_channel = '0;
    logic [11:0] mag_data    = '0;
    logic        clear_req   = 1'b0;
    logic        mode        = 1'b0;
    logic        mag_ready;
    logic        overflow_err;
    logic [95:0] freqsep_export;

    logic        v3 = 1'b0;
    logic [1:0]  c3 = '0;
    logic [11:0] d3 = '0;
    logic        rdy3;
    logic        ovf3;
    logic [71:0] exp3;

    freqsep_bank dut (
        .clk_clk        (clk),
        .reset_reset    (srst),
        .mag_valid      (mag_valid),
        .mag_ready      (mag_ready),
        .mag_channel    (mag_channel),
        .mag_data       (mag_data),
        .clear_req      (clear_req),
        .mode           (mode),
        .freqsep_export (freqsep_export),
        .overflow_err   (overflow_err)
    );

    freqsep_bank #(.CHANNELS(3)) dut3 (
        .clk_clk        (clk),
        .reset_reset    (srst),
        .mag_valid      (v3),
        .mag_ready      (rdy3),
        .mag_channel    (c3),
        .mag_data       (d3),
        .clear_req      (1'b0),
        .mode           (1'b0),
        .freqsep_export (exp3),
        .overflow_err   (ovf3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_lvl [NCH];
    int          m_hold[NCH];
    int          m_cnt = 0;
    int          clr_q[$];
    bit          m_ready = 1'b1;
    bit          m_ovf   = 1'b0;
    logic [95:0] m_exp   = '0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        int cleared;
        bit tk;
        bit acc;
        if (srst) begin
            for (int c = 0; c < NCH; c++) begin
                m_lvl[c]  = 0;
                m_hold[c] = 0;
            end
            m_cnt = 0;
            clr_q.delete();
            m_ready = 1'b1;
            m_ovf   = 1'b0;
            m_exp   = '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                logic [7:0] l8;
                l8 = 8'(m_lvl[c] >> (MW - 8));
                if (mode) m_exp[24*c +: 24] = {l8, l8, l8};
                else      m_exp[24*c +: 24] = {l8, 8'(255 - int'(l8)), 8'h00};
            end
            tk    = (m_cnt == TD - 1);
            m_cnt = (m_cnt + 1) % TD;
            acc   = mag_valid && m_ready;
            if (acc && int'(mag_channel) >= NCH) m_ovf = 1'b1;
            cleared = -1;
            if (clr_q.size() > 0) begin
                cleared = clr_q.pop_front();
            end else if (clear_req) begin
                for (int c = 0; c < NCH; c++) clr_q.push_back(c);
            end
            for (int c = 0; c < NCH; c++) begin
                if (c == cleared) begin
                    m_lvl[c]  = 0;
                    m_hold[c] = 0;
                end else if (acc && int'(mag_channel) == c && int'(mag_data) >= m_lvl[c]) begin
                    m_lvl[c]  = int'(mag_data);
                    m_hold[c] = HT;
                end else if (tk) begin
                    if (m_hold[c] > 0) m_hold[c]--;
                    else m_lvl[c] = (m_lvl[c] > DS) ? m_lvl[c] - DS : 0;
                end
            end
            m_ready = (clr_q.size() == 0);
        end
    endtask

    // One clock: update the model at the edge, compare just after it.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("export", freqsep_export, m_exp);
        chk("ready", 96'(mag_ready), 96'(m_ready));
        chk("overflow", 96'(overflow_err), 96'(m_ovf));
    endtask

    initial begin
        logic [23:0] prev;
        logic [23:0] cur;
        logic [23:0] first_chg;
        logic [23:0] last_before;
        int          changes;
        int          cnt;

        // Reset
        srst = 1'b1;
        repeat (3) step();
        chk("reset_export_zero", freqsep_export, 96'h0);
        srst = 1'b0;
        step();
        chk("idle_export", freqsep_export, {4{24'h00FF00}});
        chk("idle_ready", 96'(mag_ready), 96'd1);
        chk("idle_ovf", 96'(overflow_err), 96'd0);
        chk("ch3_idle_export", 96'(exp3), 96'({3{24'h00FF00}}));
        chk("ch3_idle_ovf", 96'(ovf3), 96'd0);

        // Full-scale peak on band 2
        mag_valid = 1'b1; mag_channel = 2'd2; mag_data = 12'hFFF;
        step();
        mag_valid = 1'b0;
        step();
        chk("peak_slice2", 96'(freqsep_export[71:48]), 96'(24'hFF0000));
        chk("peak_others", {freqsep_export[95:72], freqsep_export[47:0]}, 96'({3{24'h00FF00}}));

        // Hold then decay down to zero
        changes = 0; first_chg = '0; last_before = '0;
        prev = freqsep_export[71:48];
        for (int i = 0; i < 120; i++) begin
            step();
            cur = freqsep_export[71:48];
            if (cur !== prev) begin
                changes++;
                if (changes == 1) first_chg = cur;
                if (cur == 24'h00FF00) begin
                    last_before = prev;
                    break;
                end
                prev = cur;
            end
        end
        chk("first_decay", 96'(first_chg), 96'(24'hEF1000));
        chk("last_nonzero", 96'(last_before), 96'(24'h0FF000));
        chk("decay_steps", 96'(changes), 96'd16);

        // Non-raising sample, hold reload, mono mode
        mag_valid = 1'b1; mag_channel = 2'd1; mag_data = 12'h800;
        step();
        mag_data = 12'h100;
        step();
        mag_data = 12'h800;
        step();
        mag_valid = 1'b0;
        mode = 1'b1;
        step();
        chk("mono_slice1", 96'(freqsep_export[47:24]), 96'(24'h808080));
        repeat (12) step();
        mode = 1'b0;
        repeat (30) step();

        // Sequenced clear with a sample dropped during the window
        for (int c = 0; c < NCH; c++) begin
            mag_valid = 1'b1; mag_channel = 2'(c); mag_data = 12'hFFF;
            step();
        end
        mag_valid = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        mag_valid = 1'b1; mag_channel = 2'd3; mag_data = 12'hFFF;
        cnt = 0;
        while (mag_ready == 1'b0 && cnt < 20) begin
            cnt++;
            step();
        end
        mag_valid = 1'b0;
        chk("clear_len", 96'(cnt), 96'd4);
        step();
        chk("after_clear", freqsep_export, {4{24'h00FF00}});

        // Reset in the middle of a clear
        mag_valid = 1'b1; mag_channel = 2'd0; mag_data = 12'hFFF;
        step();
        mag_valid = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        step();
        srst = 1'b1;
        step();
        chk("midclear_rst_export", freqsep_export, 96'h0);
        chk("midclear_rst_ready", 96'(mag_ready), 96'd1);
        srst = 1'b0;
        step();
        chk("post_rst_export", freqsep_export, {4{24'h00FF00}});

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            mag_valid   = 1'($urandom_range(0, 1));
            mag_channel = 2'($urandom_range(0, 3));
            mag_data    = ($urandom_range(0, 3) == 0) ? 12'hFFF - 12'($urandom_range(0, 15))
                                                      : 12'($urandom);
            clear_req   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            step();
        end
        mag_valid = 1'b0; clear_req = 1'b0; mode = 1'b0;
        step();

        // Out-of-range channel on the three-band instance
        v3 = 1'b1; c3 = 2'd3; d3 = 12'hFFF;
        step();
        v3 = 1'b0;
        chk("ch3_ovf_set", 96'(ovf3), 96'd1);
        chk("ch3_export_unchanged", 96'(exp3), 96'({3{24'h00FF00}}));
        repeat (6) step();
        chk("ch3_ovf_sticky", 96'(ovf3), 96'd1);
        chk("ch3_export_still", 96'(exp3), 96'({3{24'h00FF00}}));
        chk("ch3_ready", 96'(rdy3), 96'd1);
        srst = 1'b1;
        step();
        chk("ch3_ovf_reset", 96'(ovf3), 96'd0);
        srst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/freqsep_bank.md
# freqsep_bank

Parametrised per-band level engine for the audio visualizer. It accepts band magnitudes one channel at a time from the processor or FFT side. For each channel it applies peak-hold and timed linear decay, then maps the level to a packed 24-bit RGB word per channel for the LED driver. It generalises the fixed two-output freqsep exports to CHANNELS bands, adds selectable colour mode, and adds a sequenced clear.

## Interface
- CHANNELS, 4: number of bands, ≥1; CH_W = max(1, clog2(CHANNELS))
- MAG_W, 12: magnitude width, ≥8
- HOLD_TICKS, 2: decay ticks a new peak is held before decay starts, ≥0
- TICK_DIV, 4: clock cycles per decay tick, ≥1
- DECAY_STEP, 256: amount subtracted from the level per decay tick after hold

Ports:
- clk_clk  in  1  single clock
- reset_reset  in  1  synchronous, active-high reset
- mag_valid  in  1  magnitude sample present
- mag_ready  out  1  block accepts samples
- mag_channel  in  CH_W  target band
- mag_data  in  MAG_W  unsigned magnitude
- clear_req  in  1  single-cycle request to zero all bands
- mode  in  1  0 = green→red gradient, 1 = mono white
- freqsep_export  out  CHANNELS*24  channel c occupies [24c+23:24c], {R,G,B}
- overflow_err  out  1  sticky: a sample was accepted with mag_channel ≥ CHANNELS

## Operation
- Per-channel state: level[c] (MAG_W bits) and hold[c] (counter, width clog2(HOLD_TICKS+1)).
- Accept when mag_valid && mag_ready.
- Accepted sample, valid channel, mag_data ≥ level[c]: set level[c] to mag_data and hold[c] to HOLD_TICKS.
- Accepted sample, valid channel, mag_data < level[c]: no effect.
- Accepted sample, channel out of range: no level change; overflow_err set to 1 and held until reset.
- Prescaler counts 0..TICK_DIV-1 and wraps. The tick pulse occurs in the cycle where the count equals TICK_DIV-1.
- On a tick, each channel not raised by a sample in the same cycle:
  - hold>0: decrement hold.
  - hold=0: level = (level > DECAY_STEP) ? level−DECAY_STEP : 0. The subtraction saturates and never wraps.
- Simultaneous tick and raising sample on the same channel: the sample wins and that channel's tick is skipped. A non-raising sample does not block decay.
- Colour mapping, with l8 = level[MAG_W-1 -: 8]:
  - mode 0: {l8, 8'hFF−l8, 8'h00}
  - mode 1: {l8, l8, l8}
- FSM:
  - IDLE: mag_ready=1. clear_req moves to CLEAR with idx=0.
  - CLEAR: mag_ready=0. Each cycle zero level[idx] and hold[idx] and increment idx. After idx=CHANNELS−1, return to IDLE.
  - clear_req while in CLEAR is ignored.
  - Decay keeps running on channels not yet cleared. Channels already cleared stay at 0.
  - Samples presented while mag_ready=0 are dropped, not queued.

## Timing
- Reset (synchronous, any state including mid-CLEAR) sets:
  - all level and hold to 0, prescaler to 0, state to IDLE
  - mag_ready=1, overflow_err=0, freqsep_export=0
- freqsep_export is registered and recomputed every cycle from level[] and mode.
  - First cycle after reset deasserts: 00FF00 per channel in mode 0, 000000 in mode 1.
- Latency:
  - Sample accepted in cycle n: level updated at the n+1 edge, export at the n+2 edge.
  - mode change: export reflects it after 1 cycle.
  - overflow_err asserts 1 cycle after the offending accept.
- Prescaler is not reset by clear_req or by samples.
- Clear duration: exactly CHANNELS cycles with mag_ready=0. mag_ready returns to 1 in the cycle after the last channel is cleared.

## Test plan
Defaults apply unless stated (CHANNELS=4, MAG_W=12, HOLD_TICKS=2, TICK_DIV=4, DECAY_STEP=256).
- Reset, mode 0, no samples → every 24-bit slice = 24'h00FF00; mag_ready=1; overflow_err=0.
- Sample ch2=0xFFF in cycle n → slice 2 = FF0000 at n+2; slices 0, 1, 3 stay 00FF00.
- Hold and decay, continuing from the previous scenario, no further samples:
  - Slice 2 stays FF0000 for 2 ticks, becomes EF1000 on the 3rd tick.
  - Reaches 0 (00FF00) after 16 decay ticks: the last step 0x0FF→0 saturates.
- Level 0x800 on ch1; sample ch1=0x100 → no change; sample ch1=0x800 → hold reloaded, decay delayed by 2 ticks; mode=1 → slice 1 = 808080 after 1 cycle.
- Set all channels high, pulse clear_req:
  - mag_ready=0 for exactly 4 cycles; a sample driven in that window is dropped.
  - All slices read 00FF00 afterwards.
  - Assert reset mid-clear → immediate IDLE with export=0.
- CHANNELS=3 instance, sample channel 3 = 0xFFF → overflow_err=1 from the next cycle and stays 1; no slice changes; cleared only by reset.
